// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential binary32 multiplier.
package fp_mul_pkg;

   typedef enum logic [2:0] {
      RmRne = 3'b000,
      RmRtz = 3'b001,
      RmRdn = 3'b010,
      RmRup = 3'b011,
      RmRmm = 3'b100
   } r_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      NORM_RND,
      DONE
   } state_e;

   localparam int unsigned BIAS    = 127;
   localparam logic [7:0]  EXP_MAX = 8'hFE;
   localparam logic [7:0]  EXP_INF = 8'hFF;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [30:0] MAXF    = 31'h7F7F_FFFF;

endpackage

// File: rtl/fp_mul_round.sv
// Normalize, round and range-check a raw 48-bit significand product.
module fp_mul_round
   import fp_mul_pkg::*;
(
   input  logic               sign_i,
   input  logic signed [9:0]  exp_i,
   input  logic        [47:0] prod_i,
   input  logic        [2:0]  rm_i,
   output logic        [31:0] z_o,
   output logic               ovrf_o,
   output logic               udrf_o
);

   logic signed [9:0] e_norm;
   logic signed [9:0] e_rnd;
   logic        [22:0] mant;
   logic        [23:0] mant_r;
   logic               guard;
   logic               sticky;
   logic               inc;

   always_comb begin
      // Product of two [1,2) significands lies in [1,4): bit 47 selects the shift.
      if (prod_i[47]) begin
         e_norm = exp_i + 10'sd1;
         mant   = prod_i[46:24];
         guard  = prod_i[23];
         sticky = |prod_i[22:0];
      end else begin
         e_norm = exp_i;
         mant   = prod_i[45:23];
         guard  = prod_i[22];
         sticky = |prod_i[21:0];
      end

      case (rm_i)
         RmRtz:   inc = 1'b0;
         RmRdn:   inc = sign_i & (guard | sticky);
         RmRup:   inc = ~sign_i & (guard | sticky);
         RmRmm:   inc = guard;
         default: inc = guard & (sticky | mant[0]);
      endcase

      mant_r = {1'b0, mant} + {23'd0, inc};
      e_rnd  = e_norm + $signed({9'd0, mant_r[23]});

      z_o    = {sign_i, e_rnd[7:0], mant_r[22:0]};
      ovrf_o = 1'b0;
      udrf_o = 1'b0;

      if (e_norm < 10'sd1) begin
         udrf_o = 1'b1;
         z_o    = {sign_i, 31'd0};
      end else if (e_rnd > $signed({2'b00, EXP_MAX})) begin
         ovrf_o = 1'b1;
         case (rm_i)
            RmRtz:   z_o = {sign_i, MAXF};
            RmRdn:   z_o = sign_i ? {1'b1, EXP_INF, 23'd0} : {1'b0, MAXF};
            RmRup:   z_o = sign_i ? {1'b1, MAXF} : {1'b0, EXP_INF, 23'd0};
            default: z_o = {sign_i, EXP_INF, 23'd0};
         endcase
      end
   end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 binary32 multiplier: iterative shift-add significand product,
// valid/ready handshake on both sides, flush-to-zero on subnormal inputs and results.
module fp_mul_seq
   import fp_mul_pkg::*;
#(
   parameter int unsigned STEPS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] fp_X,
   input  logic [31:0] fp_Y,
   input  logic [2:0]  r_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] fp_Z,
   output logic        ovrf,
   output logic        udrf,
   output logic [47:0] dbg_frc_Z_full
);

   localparam int unsigned N    = 24 / STEPS;
   localparam int unsigned CntW = 5;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [47:0]       mcand_q, mcand_d;
   logic [23:0]       mplier_q, mplier_d;
   logic [47:0]       acc_q, acc_d;
   logic              sign_q, sign_d;
   logic signed [9:0] exp_q, exp_d;
   logic [2:0]        rm_q, rm_d;
   logic [31:0]       z_q, z_d;
   logic              ovrf_q, ovrf_d;
   logic              udrf_q, udrf_d;
   logic [47:0]       dbg_q, dbg_d;

   logic [47:0] pp_sum;
   logic [31:0] rnd_z;
   logic        rnd_ovrf;
   logic        rnd_udrf;

   logic x_nan, x_inf, x_zs, y_nan, y_inf, y_zs;
   logic is_special;
   logic s_in;
   logic [31:0] spec_z;

   fp_mul_round u_round (
      .sign_i (sign_q),
      .exp_i  (exp_q),
      .prod_i (acc_q),
      .rm_i   (rm_q),
      .z_o    (rnd_z),
      .ovrf_o (rnd_ovrf),
      .udrf_o (rnd_udrf)
   );

   // Operand classification on the live inputs, used only in the accept cycle.
   always_comb begin
      x_nan = (&fp_X[30:23]) & (|fp_X[22:0]);
      x_inf = (&fp_X[30:23]) & ~(|fp_X[22:0]);
      x_zs  = ~(|fp_X[30:23]);
      y_nan = (&fp_Y[30:23]) & (|fp_Y[22:0]);
      y_inf = (&fp_Y[30:23]) & ~(|fp_Y[22:0]);
      y_zs  = ~(|fp_Y[30:23]);
      s_in  = fp_X[31] ^ fp_Y[31];

      is_special = x_nan | y_nan | x_inf | y_inf | x_zs | y_zs;
      if (x_nan | y_nan | (x_inf & y_zs) | (y_inf & x_zs)) begin
         spec_z = QNAN;
      end else if (x_inf | y_inf) begin
         spec_z = {s_in, EXP_INF, 23'd0};
      end else begin
         spec_z = {s_in, 31'd0};
      end
   end

   // STEPS partial products retired per MUL cycle.
   always_comb begin
      pp_sum = '0;
      for (int i = 0; i < int'(STEPS); i++) begin
         if (mplier_q[i]) begin
            pp_sum = pp_sum + (mcand_q << i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      rm_d     = rm_q;
      z_d      = z_q;
      ovrf_d   = ovrf_q;
      udrf_d   = udrf_q;
      dbg_d    = dbg_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               rm_d     = r_mode;
               sign_d   = s_in;
               exp_d    = {2'b00, fp_X[30:23]} + {2'b00, fp_Y[30:23]} - 10'(BIAS);
               mcand_d  = {24'd0, 1'b1, fp_X[22:0]};
               mplier_d = {1'b1, fp_Y[22:0]};
               acc_d    = '0;
               cnt_d    = '0;
               if (is_special) begin
                  z_d     = spec_z;
                  ovrf_d  = 1'b0;
                  udrf_d  = 1'b0;
                  dbg_d   = '0;
                  state_d = DONE;
               end else begin
                  state_d = MUL;
               end
            end
         end
         MUL: begin
            acc_d    = acc_q + pp_sum;
            mcand_d  = mcand_q << STEPS;
            mplier_d = mplier_q >> STEPS;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntW'(N - 1)) begin
               state_d = NORM_RND;
            end
         end
         NORM_RND: begin
            z_d     = rnd_z;
            ovrf_d  = rnd_ovrf;
            udrf_d  = rnd_udrf;
            dbg_d   = acc_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         rm_q     <= '0;
         z_q      <= '0;
         ovrf_q   <= 1'b0;
         udrf_q   <= 1'b0;
         dbg_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         rm_q     <= rm_d;
         z_q      <= z_d;
         ovrf_q   <= ovrf_d;
         udrf_q   <= udrf_d;
         dbg_q    <= dbg_d;
      end
   end

   assign in_ready       = (state_q == IDLE);
   assign out_valid      = (state_q == DONE);
   assign fp_Z           = z_q;
   assign ovrf           = ovrf_q;
   assign udrf           = udrf_q;
   assign dbg_frc_Z_full = dbg_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed, table-driven bench for fp_mul_seq with hand-computed expected results.
module tb_fp_mul_seq;

   localparam int unsigned STEPS = 1;
   localparam int LN = 24 / STEPS + 2;  // normal-op latency in edges, accept edge included
   localparam int LS = 1;               // special-op latency

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] fp_X = '0;
   logic [31:0] fp_Y = '0;
   logic [2:0]  r_mode = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] fp_Z;
   logic        ovrf;
   logic        udrf;
   logic [47:0] dbg_frc_Z_full;

   int checks = 0;
   int errors = 0;

   fp_mul_seq #(.STEPS(STEPS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .fp_X           (fp_X),
      .fp_Y           (fp_Y),
      .r_mode         (r_mode),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .fp_Z           (fp_Z),
      .ovrf           (ovrf),
      .udrf           (udrf),
      .dbg_frc_Z_full (dbg_frc_Z_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [2:0]  rm;
      logic [31:0] z;
      logic        ov;
      logic        ud;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
      if (x[30:23] == 8'd0 || y[30:23] == 8'd0 || &x[30:23] || &y[30:23]) return 48'd0;
      return {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
   endfunction

   // Issue one op, count edges from the accept edge to out_valid, capture and release.
   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                        input bit release_now, output logic [31:0] z, output logic ov,
                        output logic ud, output logic [47:0] dbg, output int edges);
      int w;
      @(negedge clk);
      fp_X = x;
      fp_Y = y;
      r_mode = rm;
      in_valid = 1'b1;
      out_ready = 1'b0;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
      z = fp_Z;
      ov = ovrf;
      ud = udrf;
      dbg = dbg_frc_Z_full;
      if (release_now) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] z;
      logic        ov, ud;
      logic [47:0] dbg;
      int          edges;
      logic [31:0] z_hold;

      vecs.push_back('{32'h3FC00000, 32'h40000000, 3'b000, 32'h40400000, 1'b0, 1'b0, LN});
      vecs.push_back('{32'h3F800001, 32'h3F800001, 3'b000, 32'h3F800002, 1'b0, 1'b0, LN});
      vecs.push_back('{32'h3F800001, 32'h3F800001, 3'b011, 32'h3F800003, 1'b0, 1'b0, LN});
      vecs.push_back('{32'h7F000000, 32'h7F000000, 3'b000, 32'h7F800000, 1'b1, 1'b0, LN});
      vecs.push_back('{32'h7F000000, 32'h7F000000, 3'b001, 32'h7F7FFFFF, 1'b1, 1'b0, LN});
      vecs.push_back('{32'h7F000000, 32'h7F000000, 3'b010, 32'h7F7FFFFF, 1'b1, 1'b0, LN});
      vecs.push_back('{32'h7F000000, 32'h7F000000, 3'b011, 32'h7F800000, 1'b1, 1'b0, LN});
      vecs.push_back('{32'hFF000000, 32'h7F000000, 3'b010, 32'hFF800000, 1'b1, 1'b0, LN});
      vecs.push_back('{32'hFF000000, 32'h7F000000, 3'b011, 32'hFF7FFFFF, 1'b1, 1'b0, LN});
      vecs.push_back('{32'hFF000000, 32'h7F000000, 3'b100, 32'hFF800000, 1'b1, 1'b0, LN});
      vecs.push_back('{32'h00800000, 32'h3F000000, 3'b000, 32'h00000000, 1'b0, 1'b1, LN});
      vecs.push_back('{32'h00800000, 32'h3F800000, 3'b000, 32'h00800000, 1'b0, 1'b0, LN});
      vecs.push_back('{32'h00000001, 32'hBF800000, 3'b000, 32'h80000000, 1'b0, 1'b0, LS});
      vecs.push_back('{32'h3FFFFFFE, 32'h3F800001, 3'b000, 32'h40000000, 1'b0, 1'b0, LN});
      vecs.push_back('{32'h3FFFFFFE, 32'h3F800001, 3'b001, 32'h3FFFFFFF, 1'b0, 1'b0, LN});
      vecs.push_back('{32'h7F7FFFFE, 32'h3F800001, 3'b000, 32'h7F800000, 1'b1, 1'b0, LN});
      vecs.push_back('{32'h7F7FFFFE, 32'h3F800001, 3'b001, 32'h7F7FFFFF, 1'b0, 1'b0, LN});
      vecs.push_back('{32'h3F800000, 32'hBF800000, 3'b111, 32'hBF800000, 1'b0, 1'b0, LN});
      vecs.push_back('{32'h7F800000, 32'h00000000, 3'b000, 32'h7FC00000, 1'b0, 1'b0, LS});
      vecs.push_back('{32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 1'b0, 1'b0, LS});
      vecs.push_back('{32'hFF800000, 32'h40000000, 3'b000, 32'hFF800000, 1'b0, 1'b0, LS});

      // Reset state
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_fp_Z", 64'(fp_Z), 64'd0);
      chk("rst_flags", 64'({ovrf, udrf}), 64'd0);
      chk("rst_dbg", 64'(dbg_frc_Z_full), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         do_op(vecs[i].x, vecs[i].y, vecs[i].rm, 1'b1, z, ov, ud, dbg, edges);
         chk($sformatf("v%0d_z", i), 64'(z), 64'(vecs[i].z));
         chk($sformatf("v%0d_ovrf", i), 64'(ov), 64'(vecs[i].ov));
         chk($sformatf("v%0d_udrf", i), 64'(ud), 64'(vecs[i].ud));
         chk($sformatf("v%0d_lat", i), 64'(edges), 64'(vecs[i].lat));
         chk($sformatf("v%0d_dbg", i), 64'(dbg), 64'(ref_prod(vecs[i].x, vecs[i].y)));
      end

      // Hold the result with out_ready low; outputs and in_ready must stay put.
      do_op(32'h7F800000, 32'h00000000, 3'b000, 1'b0, z, ov, ud, dbg, edges);
      chk("hold_lat", 64'(edges), 64'd1);
      z_hold = z;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold%0d_valid", c), 64'(out_valid), 64'd1);
         chk($sformatf("hold%0d_in_ready", c), 64'(in_ready), 64'd0);
         chk($sformatf("hold%0d_z", c), 64'(fp_Z), 64'(z_hold));
         chk($sformatf("hold%0d_flags", c), 64'({ovrf, udrf}), 64'd0);
      end
      chk("hold_z_val", 64'(z_hold), 64'h7FC00000);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      fp_X = 32'h3F800000;
      fp_Y = 32'h3F800000;
      #1;
      chk("release_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk("after_release_valid", 64'(out_valid), 64'd0);
      chk("after_release_in_ready", 64'(in_ready), 64'd1);

      // Reset in the middle of MUL drops the op without emitting anything.
      do_op(32'h3FC00000, 32'h40000000, 3'b000, 1'b1, z, ov, ud, dbg, edges);
      chk("pre_rst_z", 64'(z), 64'h40400000);
      @(negedge clk);
      fp_X = 32'h40400000;
      fp_Y = 32'h40400000;
      r_mode = 3'b000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("mid_mul_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_z", 64'(fp_Z), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      edges = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) edges++;
      end
      chk("no_partial_result", 64'(edges), 64'd0);
      do_op(32'h40400000, 32'h40400000, 3'b000, 1'b1, z, ov, ud, dbg, edges);
      chk("post_rst_z", 64'(z), 64'h41100000);
      chk("post_rst_flags", 64'({ov, ud}), 64'd0);
      chk("post_rst_lat", 64'(edges), 64'(LN));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
